// File: rtl/axis_crc_pkg.sv
// Shared constants, FSM state type and the masked byte-wise CRC-32 update
// used by axis_crc_append and its verification model.
package axis_crc_pkg;

  localparam int unsigned CRC_W      = 32;
  localparam int unsigned BEAT_BYTES = 4;

  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_XOROUT    = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC32_CHECK     = 32'hCBF43926;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_CRC  = 2'd2
  } state_e;

  // Reflected CRC-32 over the kept bytes of one beat, byte 0 first.
  function automatic logic [CRC_W-1:0] crc32_next(input logic [CRC_W-1:0]      crc,
                                                  input logic [8*BEAT_BYTES-1:0] data,
                                                  input logic [BEAT_BYTES-1:0]   keep);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int k = 0; k < int'(BEAT_BYTES); k++) begin
      if (keep[k]) begin
        c = c ^ {24'h0, data[8*k +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_crc_append.sv
// AXI-Stream stage that forwards packets and optionally appends their
// Ethernet CRC-32 as one extra beat; counts packets leaving the master port.
module axis_crc_append
  import axis_crc_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned USER_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   s_tdata,
  input  logic [DATA_SIZE/8-1:0] s_tkeep,
  input  logic [USER_SIZE-1:0]   s_tuser,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic [DATA_SIZE-1:0]   m_tdata,
  output logic [DATA_SIZE/8-1:0] m_tkeep,
  output logic [USER_SIZE-1:0]   m_tuser,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic                   crc_en,
  output logic [31:0]            pkt_cnt
);

  localparam int unsigned KEEP_W = DATA_SIZE / 8;

  state_e               state_q,    state_d;
  logic [CRC_W-1:0]     crc_q,      crc_d;
  logic                 pkt_en_q,   pkt_en_d;
  logic [USER_SIZE-1:0] user_lat_q, user_lat_d;
  logic [DATA_SIZE-1:0] m_tdata_q,  m_tdata_d;
  logic [KEEP_W-1:0]    m_tkeep_q,  m_tkeep_d;
  logic [USER_SIZE-1:0] m_tuser_q,  m_tuser_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q,  m_tlast_d;
  logic [31:0]          pkt_cnt_q,  pkt_cnt_d;

  logic             out_free;
  logic             s_hs;
  logic             m_hs;
  logic             first_beat;
  logic             beat_en;
  logic [CRC_W-1:0] crc_base;

  // Output register can take a new beat when empty or draining this cycle.
  assign out_free   = !m_tvalid_q || m_tready;
  assign s_tready   = !reset && (state_q != ST_CRC) && out_free;
  assign s_hs       = s_tvalid && s_tready;
  assign m_hs       = m_tvalid_q && m_tready;
  assign first_beat = (state_q == ST_IDLE);
  assign beat_en    = first_beat ? crc_en : pkt_en_q;
  assign crc_base   = first_beat ? CRC32_INIT : crc_q;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    pkt_en_d   = pkt_en_q;
    user_lat_d = user_lat_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tuser_d  = m_tuser_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    pkt_cnt_d  = (m_hs && m_tlast_q) ? pkt_cnt_q + 32'd1 : pkt_cnt_q;

    if (m_hs) begin
      m_tvalid_d = 1'b0;
    end

    if (s_hs) begin
      crc_d = crc32_next(crc_base, s_tdata, s_tkeep);
      if (first_beat) begin
        pkt_en_d   = crc_en;
        user_lat_d = s_tuser;
      end
      m_tdata_d  = s_tdata;
      m_tkeep_d  = s_tkeep;
      m_tuser_d  = s_tuser;
      m_tlast_d  = s_tlast && !beat_en;
      m_tvalid_d = 1'b1;
      if (!s_tlast) begin
        state_d = ST_PASS;
      end else if (beat_en) begin
        state_d = ST_CRC;
      end else begin
        state_d = ST_IDLE;
      end
    end else if ((state_q == ST_CRC) && out_free) begin
      m_tdata_d  = crc_q ^ CRC32_XOROUT;
      m_tkeep_d  = '1;
      m_tuser_d  = user_lat_q;
      m_tlast_d  = 1'b1;
      m_tvalid_d = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      crc_q      <= CRC32_INIT;
      pkt_en_q   <= 1'b0;
      user_lat_q <= '0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      pkt_en_q   <= pkt_en_d;
      user_lat_q <= user_lat_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tuser_q  <= m_tuser_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tuser  = m_tuser_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: doc/axis_crc_append.md
# axis_crc_append

Downstream stage of the session-validity packet parser. Consumes the AXI-Stream of session-valid packets and computes an Ethernet CRC-32 over the kept payload bytes. When enabled, it appends the CRC as one extra beat before forwarding the packet to the output port. It also counts forwarded packets for register readback.

## Interface
- `DATA_SIZE`, default 32, tdata width; only 32 is supported.
- `USER_SIZE`, default 16, tuser width; carries `{vlan, port_id}` from the parser, passed through untouched.
- `clk`, input, 1, single clock for the whole block.
- `reset`, input, 1, asynchronous reset, active-high. All state clears immediately on assertion.
- `s_tdata` / `s_tkeep` / `s_tuser`, input, 32 / 4 / USER_SIZE, slave stream payload.
- `s_tvalid` / `s_tlast`, input, 1 each, slave valid and end of packet.
- `s_tready`, output, 1, slave ready.
- `m_tdata` / `m_tkeep` / `m_tuser`, output, 32 / 4 / USER_SIZE, master stream payload.
- `m_tvalid` / `m_tlast`, output, 1 each, master valid and end of packet.
- `m_tready`, input, 1, master ready.
- `crc_en`, input, 1, from the `crc_mem` register. Sampled on the first beat of each packet.
- `pkt_cnt`, output, 32, number of packets completed at the master port. Wraps at 2^32.

## Operation
- **Byte order:** byte k of a beat is `tdata[8k+7:8k]`, consumed k=0..3 in that order. Only bytes with `tkeep[k]=1` enter the CRC, regardless of their position within the beat.
- **CRC algorithm:** reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF. The running CRC is re-initialised on the first beat of each packet.
- **FSM states:**
  - IDLE: waiting for a first beat.
  - PASS: mid-packet.
  - CRC: appended beat pending.
- **FSM transitions:**
  - IDLE → PASS on a handshaken beat with `s_tlast=0`.
  - IDLE or PASS, on a handshaken beat with `s_tlast=1`:
    - `pkt_en=1`: go to CRC. The forwarded beat has `m_tlast` forced to 0.
    - `pkt_en=0`: go to IDLE. The beat is forwarded unchanged with `m_tlast=1`.
  - PASS → PASS on any other handshaken beat.
  - CRC → IDLE once the CRC beat has been loaded into the output register.
- **`pkt_en`:** `crc_en` latched on the handshake of the first beat. A `crc_en` change mid-packet has no effect until the next packet.
- **CRC beat contents:**
  - `m_tdata` = final CRC, LSB byte in `tdata[7:0]`.
  - `m_tkeep` = 4'hF, `m_tlast` = 1.
  - `m_tuser` = tuser latched from the packet's first beat.
- **Pass-through beats:** tdata, tkeep and tuser are forwarded unmodified.
- **Single-beat packet** (`s_tlast` on the first beat): legal; CRC covers only that beat's kept bytes.
- **Beat with `s_tkeep=0`:** forwarded unchanged and contributes nothing to the CRC. If it also carries tlast, the CRC covers the bytes received before it.
- **`pkt_cnt`:** increments on each master handshake with `m_tlast=1`.

## Timing
- **Reset values:** `s_tready`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`/`m_tkeep`/`m_tuser`=0, `pkt_cnt`=0, FSM=IDLE.
- **Reset mid-packet:** the partial packet is discarded. After reset deasserts, the first accepted beat is treated as a first beat.
- **Output register:** one stage. Latency from slave handshake to `m_tvalid` is 1 cycle.
- **`s_tready`** = `!reset && state!=CRC && (!m_tvalid || m_tready)`. It is registered-path-free combinational from `m_tready` and state.
- **Throughput:**
  - `pkt_en=1`: an N-beat packet produces N+1 output beats. `s_tready` is low for exactly one cycle per packet (the CRC state) when `m_tready` stays high.
  - `pkt_en=0`: N in, N out, no bubble.
- **Master handshake rule:** while `m_tvalid=1 && m_tready=0`, all `m_*` outputs hold stable.
- **Back-to-back packets:** the next packet's first beat is accepted in the cycle after the CRC beat is loaded.
- **Counter wrap:** `pkt_cnt` wraps from 0xFFFFFFFF to 0.

## Structure
- **Shared package `axis_crc_pkg`:**
  - Constants: CRC32_POLY_REFL=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_XOROUT=32'hFFFFFFFF, CRC32_CHECK=32'hCBF43926.
  - FSM state enum.
  - Function `crc32_next(crc, data, keep)`: masked 4-byte update, reused by the verification model.
- **Sub-module:** none required. The output register stage stays inline.

## Test plan
- **Check value:** `crc_en=1`; beats 0x34333231/keep F, 0x38373635/keep F, 0x00000039/keep 1 with tlast, tuser 0x1234 → three beats out unchanged (third with `m_tlast=0`), then a fourth beat 0xCBF43926 / keep F / tlast / tuser 0x1234. `pkt_cnt`=1.
- **Bypass:** `crc_en=0`, same packet → exactly three output beats, tlast on the third, `pkt_cnt`=1. Then raise `crc_en` mid-packet on the next packet → still no CRC beat for that packet.
- **Back-to-back with stalls:** 100 random packets of 1–16 beats, random `s_tvalid` gaps and `m_tready` ≈50%. Every CRC beat must match the package-function model, output stays stable under stall, and `pkt_cnt`=100.
- **Zero-keep edge:** single beat, keep 0, tlast, `crc_en=1` → beat forwarded, then CRC beat 0x00000000 (CRC of an empty message).
- **Reset mid-packet:** assert `reset` after 2 beats of a 5-beat packet → `m_tvalid` and `s_tready` drop immediately. A following 1-beat packet 0x31 / keep 1 produces CRC 0x83DCEFB7.
- **Counter wrap:** force `pkt_cnt` to 0xFFFFFFFF, send one packet → `pkt_cnt`=0.
